seq_restoring_divider: RTL and testbench

//  Sequential radix-2 restoring unsigned divider: Q = A / B, R = A % B.
//  It is the inverse operator to the recursive exact multipliers, and the

---
 rtl/seq_restoring_divider.sv | 159 +++++++++++++++
 tb/tb_seq_restoring_divider.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring unsigned divider: Q = A / B, R = A % B.
// Accepts one request at a time through a valid/ready port, resolves one
// quotient bit per clock, and presents the result on a valid/ready port.
// A zero divisor skips the iteration and returns Q = all-ones, R = A,
// with div_by_zero raised.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    // Iteration counter width; derived from WIDTH, not meant to be overridden.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;

    logic [WIDTH-1:0] b_q,   b_d;     // latched divisor
    logic [WIDTH-1:0] q_q,   q_d;     // dividend shifting out / quotient shifting in
    logic [WIDTH:0]   rem_q, rem_d;   // partial remainder, one guard bit wide
    logic [CW-1:0]    cnt_q, cnt_d;   // remaining iteration steps
    logic             dbz_q, dbz_d;   // divide-by-zero flag held with the result

    logic             accept;
    logic [WIDTH:0]   shifted;        // partial remainder with next dividend bit
    logic [WIDTH:0]   trial;          // shifted minus divisor, sign in MSB
    logic             last_step;

    // The stored remainder is always below the divisor, so its guard bit
    // never carries information into the next step.
    logic             rem_msb_unused;
    assign rem_msb_unused = rem_q[WIDTH];

    assign accept    = in_valid & in_ready;
    assign shifted   = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial     = shifted - {1'b0, b_q};
    assign last_step = (cnt_q == CW'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero divisor bypasses CALC, CALC runs WIDTH steps.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (B == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: handshake flags from state, result straight from registers.
    always_comb begin
        in_ready    = (state_q == S_IDLE);
        out_valid   = (state_q == S_DONE);
        Q           = q_q;
        R           = rem_q[WIDTH-1:0];
        div_by_zero = dbz_q;
    end

    // Datapath next-state: load on accept, one restoring step per CALC cycle.
    always_comb begin
        b_d   = b_q;
        q_d   = q_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        dbz_d = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    b_d   = B;
                    cnt_d = CW'(WIDTH);
                    if (B == '0) begin
                        q_d   = '1;
                        rem_d = {1'b0, A};
                        dbz_d = 1'b1;
                    end else begin
                        q_d   = A;
                        rem_d = '0;
                        dbz_d = 1'b0;
                    end
                end
            end
            S_CALC: begin
                // Negative trial difference means the divisor does not fit:
                // keep the shifted remainder and shift in a 0 quotient bit.
                if (trial[WIDTH]) begin
                    rem_d = shifted;
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q - CW'(1);
            end
            S_DONE: begin
                // Q and R stay put after the handshake; only the flag clears.
                if (out_ready) begin
                    dbz_d = 1'b0;
                end
            end
            default: begin
                dbz_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q   <= '0;
            q_q   <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            b_q   <= b_d;
            q_q   <= q_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            dbz_q <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH = 4): directed cases,
// backpressure, mid-operation reset, and all 256 operand pairs with random
// response stalls, checked against plain integer division.
module tb_seq_restoring_divider;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] q_out;
    logic [W-1:0] r_out;
    logic         dbz;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (a_in),
        .B          (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Q          (q_out),
        .R          (r_out),
        .div_by_zero(dbz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full transaction: request, latency, result, optional stalls (with an
    // optional in_valid poke while busy), response handshake.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int unsigned stalls, input bit poke);
        int unsigned eq, er, lat, qq, rr;
        eq = (b == 0) ? (1 << W) - 1 : int'(a) / int'(b);
        er = (b == 0) ? int'(a) : int'(a) % int'(b);

        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 1);
        a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);

        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, (b == 0) ? 1 : W + 1);
        if (!out_valid) return;

        qq = q_out;
        rr = r_out;
        check_eq("quotient", qq, eq);
        check_eq("remainder", rr, er);
        check_eq("div_by_zero", dbz, (b == 0) ? 1 : 0);
        if (b != 0) begin
            check_eq("inv_product", qq * int'(b) + rr, int'(a));
            check_eq("inv_rem_lt_b", (rr < int'(b)) ? 1 : 0, 1);
        end

        for (int i = 0; i < int'(stalls); i++) begin
            @(negedge clk);
            if (poke && i == 2) begin
                a_in = 4'd9; b_in = 4'd2; in_valid = 1'b1;
                check_eq("busy_in_ready", in_ready, 0);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_q", q_out, eq);
            check_eq("stall_r", r_out, er);
            check_eq("stall_dbz", dbz, (b == 0) ? 1 : 0);
        end

        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("post_valid", out_valid, 0);
        check_eq("post_in_ready", in_ready, 1);
        check_eq("post_dbz", dbz, 0);
        check_eq("post_q_hold", q_out, eq);
        check_eq("post_r_hold", r_out, er);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_q", q_out, 0);
        check_eq("rst_r", r_out, 0);
        check_eq("rst_dbz", dbz, 0);

        // Directed cases and boundaries.
        run_one(4'd13, 4'd3, 0, 1'b0);
        run_one(4'd7,  4'd0, 1, 1'b0);
        run_one(4'd2,  4'd9, 0, 1'b0);
        run_one(4'd15, 4'd15, 0, 1'b0);
        run_one(4'd15, 4'd1, 0, 1'b0);
        run_one(4'd0,  4'd5, 0, 1'b0);

        // Backpressure with an ignored request while the result is held.
        run_one(4'd13, 4'd3, 6, 1'b1);

        // Reset two cycles into CALC aborts the operation.
        @(negedge clk);
        a_in = 4'd13; b_in = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("calc_valid", out_valid, 0);
        check_eq("calc_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("inrst_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_valid", out_valid, 0);
        check_eq("rel_in_ready", in_ready, 1);
        check_eq("rel_q", q_out, 0);
        check_eq("rel_r", r_out, 0);
        check_eq("rel_dbz", dbz, 0);
        run_one(4'd9, 4'd2, 1, 1'b0);

        // Every operand pair with random response stalls.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_one(W'(a), W'(b), $urandom_range(0, 3), 1'b0);
            end
        end

        // Extra random pairs with longer stalls.
        for (int k = 0; k < 20; k++) begin
            run_one(W'($urandom), W'($urandom), $urandom_range(0, 5), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
